svf_ctrl: RTL and testbench

Sequencer and configuration front-end for the 8-bit state variable filter. Generates the filter's sample strobe from the system clock and takes byte-wide register writes into a shadow bank. Commits configuration atomically on a sample boundary and slews the cutoff coefficient toward its target to suppress zipper noise. Mixes the enabled filter outputs into one registered 8-bit audio stream; sits between the voice mixer/register file and the filter datapath.

---
 rtl/svf_pkg.sv | 42 ++++
 rtl/svf_cutoff_slew.sv | 74 +++++++
 rtl/svf_ctrl.sv | 153 +++++++++++++++
 tb/tb_svf_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/svf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : svf_pkg
// Description : Shared constants, configuration record and mix helper for
//               the state variable filter control front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package svf_pkg;

    localparam int c_FC_W  = 11;
    localparam int c_RES_W = 2;

    localparam logic [1:0] c_FC_LO    = 2'd0;
    localparam logic [1:0] c_FC_HI    = 2'd1;
    localparam logic [1:0] c_RES_MODE = 2'd2;
    localparam logic [1:0] c_COMMIT   = 2'd3;

    localparam int c_RM_LP_EN  = 2;
    localparam int c_RM_BP_EN  = 3;
    localparam int c_RM_HP_EN  = 4;
    localparam int c_RM_BYPASS = 7;

    typedef struct packed {
        logic [c_FC_W-1:0]  fc;
        logic [c_RES_W-1:0] res;
        logic               lp_en;
        logic               bp_en;
        logic               hp_en;
        logic               bypass;
    } svf_cfg_t;

    function automatic logic signed [7:0] sat8(input logic signed [9:0] v);
        if (v > 10'sd127)
            return 8'sd127;
        else if (v < -10'sd128)
            return -8'sd128;
        else
            return v[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/svf_cutoff_slew.sv
`default_nettype none
// ============================================================================
// Module      : svf_cutoff_slew
// Description : Holds the cutoff target and steps alpha1 toward it by at most
//               SLEW_STEP per sample tick; busy flags an unsettled coefficient.
// Revision    : 1.0 - initial release
// ============================================================================
module svf_cutoff_slew
    import svf_pkg::*;
#(
    parameter int SLEW_STEP = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              load,
    input  logic [c_FC_W-1:0] target_in,
    output logic [c_FC_W-1:0] alpha1,
    output logic              busy
);

    // A zero (or oversize) step collapses to a full-scale jump.
    localparam logic [c_FC_W:0] c_STEP = (SLEW_STEP <= 0 || SLEW_STEP > 2047)
                                         ? (c_FC_W+1)'(2047)
                                         : (c_FC_W+1)'(SLEW_STEP);

    logic [c_FC_W-1:0] r_target;
    logic [c_FC_W-1:0] r_alpha1;
    logic              r_busy;
    logic [c_FC_W-1:0] w_alpha1_nx;
    logic [c_FC_W:0]   w_a;
    logic [c_FC_W:0]   w_t;
    logic [c_FC_W:0]   w_up;
    logic [c_FC_W:0]   w_dn;

    always_comb begin
        w_a         = {1'b0, r_alpha1};
        w_t         = {1'b0, r_target};
        w_up        = w_a + c_STEP;
        w_dn        = w_a - c_STEP;
        w_alpha1_nx = r_alpha1;
        if (w_a < w_t) begin
            if ((w_t - w_a) > c_STEP)
                w_alpha1_nx = w_up[c_FC_W-1:0];
            else
                w_alpha1_nx = r_target;
        end else if (w_a > w_t) begin
            if ((w_a - w_t) > c_STEP)
                w_alpha1_nx = w_dn[c_FC_W-1:0];
            else
                w_alpha1_nx = r_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_target <= '0;
            r_alpha1 <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_busy <= (r_alpha1 != r_target);
            if (tick) begin
                r_alpha1 <= w_alpha1_nx;
                if (load)
                    r_target <= target_in;
            end
        end
    end

    assign alpha1 = r_alpha1;
    assign busy   = r_busy;

endmodule
`default_nettype wire

// File: rtl/svf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : svf_ctrl
// Description : Sample strobe, shadow/commit register bank and output mixer
//               for the 8-bit SVF. SVF_CTRL_SLEW_EN enables the cutoff slewer.
// Revision    : 1.0 - initial release
// ============================================================================
module svf_ctrl
    import svf_pkg::*;
#(
    parameter int CLK_DIV   = 16,
    parameter int SLEW_STEP = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [1:0]          wr_addr,
    input  logic [7:0]          wr_data,
    input  logic signed [7:0]   audio_in,
    input  logic signed [7:0]   svf_hp,
    input  logic signed [7:0]   svf_bp,
    input  logic signed [7:0]   svf_lp,
    output logic                sample_valid,
    output logic [c_FC_W-1:0]   alpha1,
    output logic [c_RES_W-1:0]  alpha2,
    output logic signed [7:0]   audio_out,
    output logic                busy,
    output logic                commit_pending
);

    localparam int c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0]  r_cnt;
    logic                w_tick;
    svf_cfg_t            r_shadow;
    svf_cfg_t            r_pending;
    logic                r_pend;
    logic [c_RES_W-1:0]  r_alpha2;
    logic                r_lp_en;
    logic                r_bp_en;
    logic                r_hp_en;
    logic                r_bypass;
    logic signed [7:0]   r_audio;
    logic signed [9:0]   w_sum;

    assign w_tick = (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (w_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + c_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow  <= '0;
            r_pending <= '0;
            r_pend    <= 1'b0;
        end else begin
            if (wr_en) begin
                case (wr_addr)
                    c_FC_LO:    r_shadow.fc[2:0]  <= wr_data[2:0];
                    c_FC_HI:    r_shadow.fc[10:3] <= wr_data;
                    c_RES_MODE: begin
                        r_shadow.res    <= wr_data[1:0];
                        r_shadow.lp_en  <= wr_data[c_RM_LP_EN];
                        r_shadow.bp_en  <= wr_data[c_RM_BP_EN];
                        r_shadow.hp_en  <= wr_data[c_RM_HP_EN];
                        r_shadow.bypass <= wr_data[c_RM_BYPASS];
                    end
                    c_COMMIT:   r_pending <= r_shadow;
                endcase
            end
            // A fresh COMMIT on the tick cycle outranks the clear.
            if (wr_en && wr_addr == c_COMMIT)
                r_pend <= 1'b1;
            else if (w_tick)
                r_pend <= 1'b0;
        end
    end

    always_comb begin
        w_sum = '0;
        if (r_lp_en) w_sum = w_sum + {{2{svf_lp[7]}}, svf_lp};
        if (r_bp_en) w_sum = w_sum + {{2{svf_bp[7]}}, svf_bp};
        if (r_hp_en) w_sum = w_sum + {{2{svf_hp[7]}}, svf_hp};
    end

    // The mix uses the mode in force before this tick's commit lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alpha2 <= '0;
            r_lp_en  <= 1'b0;
            r_bp_en  <= 1'b0;
            r_hp_en  <= 1'b0;
            r_bypass <= 1'b1;
            r_audio  <= '0;
        end else if (w_tick) begin
            r_audio <= r_bypass ? audio_in : sat8(w_sum);
            if (r_pend) begin
                r_alpha2 <= r_pending.res;
                r_lp_en  <= r_pending.lp_en;
                r_bp_en  <= r_pending.bp_en;
                r_hp_en  <= r_pending.hp_en;
                r_bypass <= r_pending.bypass;
            end
        end
    end

`ifdef SVF_CTRL_SLEW_EN
    svf_cutoff_slew #(
        .SLEW_STEP (SLEW_STEP)
    ) u_slew (
        .clk       (clk),
        .rst       (rst),
        .tick      (w_tick),
        .load      (w_tick & r_pend),
        .target_in (r_pending.fc),
        .alpha1    (alpha1),
        .busy      (busy)
    );
`else
    logic [c_FC_W-1:0] r_target;
    logic [c_FC_W-1:0] r_alpha1;
    logic              w_unused_slew;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_target <= '0;
            r_alpha1 <= '0;
        end else if (w_tick) begin
            r_alpha1 <= r_target;
            if (r_pend)
                r_target <= r_pending.fc;
        end
    end

    assign alpha1        = r_alpha1;
    assign busy          = 1'b0;
    assign w_unused_slew = ^SLEW_STEP;
`endif

    assign sample_valid   = w_tick;
    assign alpha2         = r_alpha2;
    assign audio_out      = r_audio;
    assign commit_pending = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_svf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_svf_ctrl
// Description : Directed, table-driven bench for svf_ctrl (CLK_DIV=16,
//               SLEW_STEP=32), with sequences for commit timing and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_svf_ctrl;

    localparam int CLK_DIV   = 16;
    localparam int SLEW_STEP = 32;

    localparam logic [1:0] A_FC_LO    = 2'd0;
    localparam logic [1:0] A_FC_HI    = 2'd1;
    localparam logic [1:0] A_RES_MODE = 2'd2;
    localparam logic [1:0] A_COMMIT   = 2'd3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [1:0]        wr_addr = '0;
    logic [7:0]        wr_data = '0;
    logic signed [7:0] audio_in = '0;
    logic signed [7:0] svf_hp = '0;
    logic signed [7:0] svf_bp = '0;
    logic signed [7:0] svf_lp = '0;
    logic              sample_valid;
    logic [10:0]       alpha1;
    logic [1:0]        alpha2;
    logic signed [7:0] audio_out;
    logic              busy;
    logic              commit_pending;

    int total = 0;
    int bad   = 0;

    svf_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .SLEW_STEP (SLEW_STEP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .audio_in       (audio_in),
        .svf_hp         (svf_hp),
        .svf_bp         (svf_bp),
        .svf_lp         (svf_lp),
        .sample_valid   (sample_valid),
        .alpha1         (alpha1),
        .alpha2         (alpha2),
        .audio_out      (audio_out),
        .busy           (busy),
        .commit_pending (commit_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rm;
        int lp;
        int bp;
        int hp;
        int ain;
        int exp_out;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    // Stops at the falling edge inside the tick cycle.
    task automatic wait_sv();
        int n;
        n = 0;
        while (sample_valid !== 1'b1 && n < 2 * CLK_DIV) begin
            @(negedge clk);
            n++;
        end
        if (sample_valid !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL tick_timeout: got no strobe within %0d cycles", 2 * CLK_DIV);
        end
    endtask

    task automatic tick_pass();
        wait_sv();
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;

        vecs[0]  = '{'h1D,  100,  100,  100,   0,  127};
        vecs[1]  = '{'h1E, -100, -100, -100,   0, -128};
        vecs[2]  = '{'h03,  100,  100,  100,  55,    0};
        vecs[3]  = '{'h80,   10,   10,   10,  -5,   -5};
        vecs[4]  = '{'h04, -128,   90,   90,   0, -128};
        vecs[5]  = '{'h18,    0,   60,  -20,   0,   40};
        vecs[6]  = '{'h1C,   60,   50,   20,   0,  127};
        vecs[7]  = '{'h9C,   60,   50,   20,  33,   33};
        vecs[8]  = '{'h0D,  -70,  -60,   99,   0, -128};
        vecs[9]  = '{'h10,    1,    2,   -3,   0,   -3};
        vecs[10] = '{'h64,    7,   50,   50,   0,    7};

        repeat (3) @(negedge clk);
        chk("rst_sample_valid", int'(sample_valid), 0);
        chk("rst_alpha1", int'(alpha1), 0);
        chk("rst_alpha2", int'(alpha2), 0);
        chk("rst_audio_out", int'(audio_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_commit_pending", int'(commit_pending), 0);

        // Strobe period and bypass-at-reset
        audio_in = 8'sh40;
        rst      = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            chk("strobe", int'(sample_valid), (i % 16 == 0) ? 1 : 0);
            chk("bypass_out", int'(audio_out), (i > 16) ? 64 : 0);
            chk("alpha1_idle", int'(alpha1), 0);
            @(negedge clk);
        end

        // Mixer table
        for (int i = 0; i < 11; i++) begin
            svf_lp   = 8'(vecs[i].lp);
            svf_bp   = 8'(vecs[i].bp);
            svf_hp   = 8'(vecs[i].hp);
            audio_in = 8'(vecs[i].ain);
            wr(A_RES_MODE, 8'(vecs[i].rm));
            wr(A_COMMIT, 8'h00);
            tick_pass();
            tick_pass();
            chk("mix_out", int'(audio_out), vecs[i].exp_out);
            chk("mix_alpha2", int'(alpha2), vecs[i].rm & 3);
        end

        // Atomic commit of full-scale cutoff
        wr(A_FC_HI, 8'hFF);
        wr(A_FC_LO, 8'h07);
        wr(A_RES_MODE, 8'h06);
        wr(A_COMMIT, 8'h00);
        chk("atomic_pending_set", int'(commit_pending), 1);
        chk("atomic_alpha2_held", int'(alpha2), 0);
        chk("atomic_alpha1_held", int'(alpha1), 0);
        tick_pass();
        chk("atomic_pending_clr", int'(commit_pending), 0);
        chk("atomic_alpha2_applied", int'(alpha2), 2);
        chk("atomic_alpha1_old_target", int'(alpha1), 0);
`ifdef SVF_CTRL_SLEW_EN
        for (int k = 1; k <= 64; k++) begin
            tick_pass();
            chk("slew_step", int'(alpha1), (32 * k > 2047) ? 2047 : 32 * k);
        end
        chk("busy_at_final_step", int'(busy), 1);
        @(negedge clk);
        chk("busy_drop", int'(busy), 0);
`else
        chk("busy_tied_low", int'(busy), 0);
        tick_pass();
        chk("alpha1_jump", int'(alpha1), 2047);
        chk("busy_tied_low2", int'(busy), 0);
`endif

        // COMMIT landing on the tick cycle
        wr(A_FC_HI, 8'h20);
        wr(A_FC_LO, 8'h00);
        wr(A_RES_MODE, 8'h01);
        wait_sv();
        wr(A_COMMIT, 8'h00);
        chk("tick_commit_pending_held", int'(commit_pending), 1);
        chk("tick_commit_alpha2_held", int'(alpha2), 2);
        tick_pass();
        chk("tick_commit_pending_clr", int'(commit_pending), 0);
        chk("tick_commit_alpha2", int'(alpha2), 1);

        // Second COMMIT overwrites; uncommitted shadow write does not leak
        tick_pass();
        wr(A_FC_HI, 8'd12);
        wr(A_FC_LO, 8'd4);
        wr(A_COMMIT, 8'h00);
        wr(A_FC_HI, 8'd62);
        wr(A_FC_LO, 8'd4);
        wr(A_COMMIT, 8'h00);
        tick_pass();
        wr(A_FC_HI, 8'd112);
        wr(A_FC_LO, 8'd4);
`ifndef SVF_CTRL_SLEW_EN
        tick_pass();
        chk("overwrite_alpha1", int'(alpha1), 500);
`endif
        for (int k = 0; k < 70; k++)
            tick_pass();
        chk("overwrite_settled", int'(alpha1), 500);
        @(negedge clk);
        chk("overwrite_busy", int'(busy), 0);
        chk("overwrite_no_pending", int'(commit_pending), 0);

        // Reset mid-slew with a commit pending
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wr(A_FC_HI, 8'h80);
        wr(A_FC_LO, 8'h00);
        wr(A_COMMIT, 8'h00);
        tick_pass();
        for (int k = 0; k < 16; k++)
            tick_pass();
`ifdef SVF_CTRL_SLEW_EN
        chk("midslew_alpha1", int'(alpha1), 512);
        chk("midslew_busy", int'(busy), 1);
`else
        chk("midslew_alpha1", int'(alpha1), 1024);
        chk("midslew_busy", int'(busy), 0);
`endif
        wr(A_COMMIT, 8'h00);
        chk("midslew_pending", int'(commit_pending), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_alpha1", int'(alpha1), 0);
        chk("rst2_busy", int'(busy), 0);
        chk("rst2_pending", int'(commit_pending), 0);
        chk("rst2_alpha2", int'(alpha2), 0);
        chk("rst2_audio_out", int'(audio_out), 0);
        chk("rst2_sample_valid", int'(sample_valid), 0);
        rst = 1'b0;
        n = 1;
        while (sample_valid !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("restart_first_tick", n, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
